pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the payload width (e.g. pc and inst concatenated).
REQ-002 Parameter BUBBLE_VAL, default 0, SHALL be the DATA_W-bit value driven on out_data whenever out_valid is 0 (NOP bubble).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-low reset sampled on the rising edge of clk.
REQ-005 flush  input  1  SHALL discard all held and incoming beats when 1.
REQ-006 in_valid  input  1  SHALL mark in_data as a valid beat from the upstream stage.
REQ-007 in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-008 in_ready  output  1  SHALL indicate the stage can accept a beat this cycle.
REQ-009 out_valid  output  1  SHALL mark out_data as a valid beat for the downstream stage.
REQ-010 out_data  output  DATA_W  SHALL carry the oldest held payload.
REQ-011 out_ready  input  1  SHALL indicate downstream accepts out_data this cycle (0 = downstream stall).
REQ-012 occupancy  output  2  SHALL report held beats, 0 to 2.

Function
REQ-013 Accept SHALL occur when in_valid and in_ready are both 1; take SHALL occur when out_valid and out_ready are both 1.
REQ-014 The block SHALL hold a main entry and a skid entry, with states EMPTY (occupancy 0), ONE (1) and TWO (2).
REQ-015 in_ready, out_valid, out_data and occupancy SHALL be driven from registers only; there is no combinational path from in_* or out_ready to any output.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO.
REQ-017 out_valid SHALL be 1 in ONE and TWO; out_data SHALL equal the main entry then, else BUBBLE_VAL.
REQ-018 EMPTY: accept -> ONE with main<=in_data; no accept -> stay EMPTY.
REQ-019 ONE: accept and take -> stay ONE with main<=in_data; accept only -> TWO with skid<=in_data; take only -> EMPTY; neither -> stay ONE, main held.
REQ-020 TWO: take -> ONE with main<=skid; no take -> stay TWO, both entries held; in_valid ignored.
REQ-021 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL appear on out_data after edge N when the stage was EMPTY, or ONE with a take.
REQ-022 Beats SHALL leave in acceptance order with no loss and no duplication; throughput SHALL be 1 beat per cycle while out_ready stays 1.
REQ-023 flush=1 SHALL force EMPTY at the next edge regardless of state, in_valid or out_ready; in_ready SHALL still read 1 or 0 per state that cycle, but a simultaneous accept SHALL be dropped.
REQ-024 After a flush, out_valid SHALL be 0 and out_data SHALL be BUBBLE_VAL.
REQ-025 When occupancy is 0 the main and skid entry registers SHALL be loaded with BUBBLE_VAL (no stale payload retained).

Reset
REQ-026 rst=0 at an edge SHALL force EMPTY: out_valid=0, out_data=BUBBLE_VAL, in_ready=1, occupancy=0, skid=BUBBLE_VAL.
REQ-027 Reset SHALL take priority over flush and all handshakes.
REQ-028 Reset mid-operation SHALL discard held beats without emitting them.
REQ-029 The first accept SHALL occur at the first edge with rst=1.

Verification
REQ-030 Stream: DATA_W=64, out_ready=1, in_valid=1 with data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the next three cycles, occupancy stays 1, in_ready stays 1.
REQ-031 Backpressure: hold out_ready=0, present 0xA then 0xB -> occupancy 2 and in_ready=0; 0xC held on in_data is not accepted; raise out_ready -> 0xA, 0xB, 0xC in order with no drop.
REQ-032 Flush: state TWO holding 0xA and 0xB, flush=1 with in_valid=1 and data 0xD -> next cycle out_valid=0, out_data=0, occupancy=0; 0xD never appears on out_data.
REQ-033 Reset mid-stream: state ONE holding 0x5, drive rst=0 for one edge -> out_valid=0, out_data=BUBBLE_VAL, in_ready=1; 0x5 never appears on out_data.
REQ-034 Parameter sweep: DATA_W=32, BUBBLE_VAL=0x00000013, same stimulus as REQ-031 -> same ordering, and out_data=0x00000013 whenever out_valid=0.
REQ-035 Random in_valid and out_ready over 10k cycles -> scoreboard shows in-order, lossless, duplicate-free delivery and occupancy always 0 to 2.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register: fully registered valid/ready
// handshake with flush, NOP bubble on empty, and occupancy reporting.
module pipe_stage_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] skid;

  // out_data is the main entry itself; it is reloaded with BUBBLE_VAL
  // whenever the stage drains, so the output needs no mux.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state     <= EMPTY;
      out_data  <= BUBBLE_VAL;
      skid      <= BUBBLE_VAL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state     <= ONE;
            out_data  <= in_data;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (in_valid && out_ready) begin
            out_data <= in_data;
          end else if (in_valid) begin
            state     <= TWO;
            skid      <= in_data;
            in_ready  <= 1'b0;
            occupancy <= 2'd2;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_data  <= BUBBLE_VAL;
            skid      <= BUBBLE_VAL;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
          end
        end
        TWO: begin
          // Full: upstream is already stalled by the registered in_ready.
          if (out_ready) begin
            state     <= ONE;
            out_data  <= skid;
            skid      <= BUBBLE_VAL;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_data  <= BUBBLE_VAL;
          skid      <= BUBBLE_VAL;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

endmodule
